// File: rtl/prog_mem_responder_pkg.sv
// Shared types and constants for the program-memory responder: FSM state
// encoding and the width and saturation limit of the transaction counter.
package prog_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        READ_WAIT = 2'b01,
        RELAY     = 2'b10
    } resp_state_e;

    localparam int SERVED_COUNT_BITS = 16;
    localparam logic [SERVED_COUNT_BITS-1:0] SERVED_COUNT_MAX = '1;

endpackage

// File: rtl/prog_mem_responder_rr_arbiter.sv
// Combinational round-robin picker: returns the first asserted request found
// scanning upward from rr_ptr, wrapping past the top index.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  request,
    input  logic [PTR_BITS-1:0] rr_ptr,
    output logic [PTR_BITS-1:0] grant,
    output logic                any_request
);

    logic [PTR_BITS-1:0] idx;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop, so no path leaves a latch.
        idx         = '0;
        grant       = '0;
        any_request = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_BITS'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_request && request[idx]) begin
                any_request = 1'b1;
                grant       = idx;
            end
        end
    end

endmodule

// File: rtl/prog_mem_responder.sv
// Arbitrates several instruction-fetch consumers onto one program memory port,
// one outstanding read at a time, relaying each returned word to its requester.
module prog_mem_responder
    import prog_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,
    output logic                                     busy,
    output logic [SERVED_COUNT_BITS-1:0]             served_count
);

    localparam int PTR_BITS = $clog2(NUM_CONSUMERS);

    resp_state_e                   state, state_next;
    logic [PTR_BITS-1:0]           rr_ptr, rr_ptr_next;
    logic [PTR_BITS-1:0]           grant, grant_next;
    logic                          mem_valid_next;
    logic [ADDR_BITS-1:0]          mem_addr_next;
    logic [NUM_CONSUMERS-1:0]      ready_next;
    logic                          data_load;
    logic [SERVED_COUNT_BITS-1:0]  count_next;

    logic [PTR_BITS-1:0]           arb_grant;
    logic                          arb_any;

    rr_arbiter #(
        .NUM_REQ  (NUM_CONSUMERS),
        .PTR_BITS (PTR_BITS)
    ) u_rr_arbiter (
        .request     (consumer_read_valid),
        .rr_ptr      (rr_ptr),
        .grant       (arb_grant),
        .any_request (arb_any)
    );

    always_comb begin
        state_next     = state;
        rr_ptr_next    = rr_ptr;
        grant_next     = grant;
        mem_valid_next = mem_read_valid;
        mem_addr_next  = mem_read_address;
        ready_next     = consumer_read_ready;
        data_load      = 1'b0;
        count_next     = served_count;

        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_next     = arb_grant;
                    rr_ptr_next    = (arb_grant == PTR_BITS'(NUM_CONSUMERS - 1)) ? '0 : arb_grant + 1'b1;
                    mem_valid_next = 1'b1;
                    mem_addr_next  = consumer_read_address[arb_grant];
                    state_next     = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_valid_next    = 1'b0;
                    ready_next        = '0;
                    ready_next[grant] = 1'b1;
                    data_load         = 1'b1;
                    state_next        = RELAY;
                end
            end
            RELAY: begin
                // The consumer closes the handshake by dropping its request.
                if (!consumer_read_valid[grant]) begin
                    ready_next = '0;
                    if (served_count != SERVED_COUNT_MAX) begin
                        count_next = served_count + 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            grant               <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
            consumer_read_ready <= '0;
            // NOTE: the return-data registers are reset too, so consumers never observe stale words after reset.
            consumer_read_data  <= '0;
            served_count        <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state               <= state_next;
            rr_ptr              <= rr_ptr_next;
            grant               <= grant_next;
            mem_read_valid      <= mem_valid_next;
            mem_read_address    <= mem_addr_next;
            consumer_read_ready <= ready_next;
            served_count        <= count_next;
            if (data_load) begin
                consumer_read_data[grant] <= mem_read_data;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_prog_mem_responder.sv
// Self-checking bench for prog_mem_responder: table-driven single transactions,
// directed arbitration/reset sequences, and a randomized run against a model.
module tb_prog_mem_responder;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NC = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NC-1:0]           consumer_read_valid;
    logic [NC-1:0][AW-1:0]   consumer_read_address;
    logic [NC-1:0]           consumer_read_ready;
    logic [NC-1:0][DW-1:0]   consumer_read_data;
    logic                    mem_read_valid;
    logic [AW-1:0]           mem_read_address;
    logic                    mem_read_ready;
    logic [DW-1:0]           mem_read_data;
    logic                    busy;
    logic [15:0]             served_count;

    int checks    = 0;
    int errors    = 0;
    int exp_count = 0;

    typedef struct {
        int          cons;
        logic [7:0]  addr;
        int          delay;
        logic [15:0] data;
        int          hold;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
        int          exp_ready_cycles;
    } vec_t;

    vec_t vecs [5];

    prog_mem_responder #(
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW),
        .NUM_CONSUMERS (NC)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (consumer_read_valid),
        .consumer_read_address (consumer_read_address),
        .consumer_read_ready   (consumer_read_ready),
        .consumer_read_data    (consumer_read_data),
        .mem_read_valid        (mem_read_valid),
        .mem_read_address      (mem_read_address),
        .mem_read_ready        (mem_read_ready),
        .mem_read_data         (mem_read_data),
        .busy                  (busy),
        .served_count          (served_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] mem_fn(input logic [7:0] a);
        return {a, ~a} ^ 16'h5A3C;
    endfunction

    // Round-robin rule: first requester at or above ptr, wrapping.
    function automatic int rr_pick(input logic [NC-1:0] req, input int ptr);
        for (int k = 0; k < NC; k++) begin
            if (req[(ptr + k) % NC]) return (ptr + k) % NC;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " mem_valid"}, mem_read_valid, 0);
        check({tag, " mem_addr"}, mem_read_address, 0);
        check({tag, " ready"}, consumer_read_ready, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " count"}, served_count, 0);
        for (int i = 0; i < NC; i++) check({tag, " data"}, consumer_read_data[i], 0);
    endtask

    task automatic apply_reset();
        reset                 = 1'b0;
        consumer_read_valid   = '0;
        consumer_read_address = '0;
        mem_read_ready        = 1'b0;
        mem_read_data         = '0;
        exp_count             = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_mem_valid(input string tag);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_read_valid === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check({tag, " mem_valid timeout"}, 0, 1);
    endtask

    // Memory answers after `delay` cycles; consumer c drops valid on first sight of ready.
    task automatic serve(input int c, input int delay, input logic [15:0] d, input string tag);
        repeat (delay) @(negedge clk);
        mem_read_ready = 1'b1;
        mem_read_data  = d;
        @(negedge clk);
        mem_read_ready = 1'b0;
        check({tag, " ready"}, consumer_read_ready, 32'(1 << c));
        check({tag, " data"}, consumer_read_data[c], d);
        consumer_read_valid[c] = 1'b0;
        exp_count++;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit held;
        bit no_new_mem;
        int ready_cycles;
        int other;
        other = (v.cons + 1) % NC;
        consumer_read_address[v.cons] = v.addr;
        consumer_read_valid[v.cons]   = 1'b1;
        @(negedge clk);
        check({tag, " grant latency"}, mem_read_valid, 1);
        check({tag, " mem_addr"}, mem_read_address, v.exp_addr);
        check({tag, " busy"}, busy, 1);
        held = 1;
        repeat (v.delay) begin
            @(negedge clk);
            held &= mem_read_valid;
        end
        check({tag, " mem_valid held"}, held, 1);
        mem_read_ready = 1'b1;
        mem_read_data  = v.data;
        @(negedge clk);
        mem_read_ready = 1'b0;
        check({tag, " ready"}, consumer_read_ready, 32'(1 << v.cons));
        check({tag, " data"}, consumer_read_data[v.cons], v.exp_data);
        check({tag, " mem_valid cleared"}, mem_read_valid, 0);
        // A second consumer asks during the relay and withdraws before it could be granted.
        consumer_read_address[other] = 8'hEE;
        consumer_read_valid[other]   = 1'b1;
        ready_cycles = 1;
        no_new_mem   = 1;
        for (int i = 1; i < v.hold; i++) begin
            @(negedge clk);
            if (consumer_read_ready[v.cons]) ready_cycles++;
            if (mem_read_valid) no_new_mem = 0;
        end
        consumer_read_valid[v.cons] = 1'b0;
        consumer_read_valid[other]  = 1'b0;
        exp_count++;
        @(negedge clk);
        check({tag, " ready dropped"}, consumer_read_ready, 0);
        check({tag, " count"}, served_count, exp_count);
        check({tag, " ready cycles"}, ready_cycles, v.exp_ready_cycles);
        check({tag, " no mem during relay"}, no_new_mem, 1);
        @(negedge clk);
        check({tag, " withdrawn not granted"}, mem_read_valid, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    initial begin
        vecs[0] = '{2, 8'h05, 3, 16'hA1B2, 1, 8'h05, 16'hA1B2, 1};
        vecs[1] = '{0, 8'hFF, 0, 16'hFFFF, 2, 8'hFF, 16'hFFFF, 2};
        vecs[2] = '{3, 8'h00, 1, 16'h0000, 5, 8'h00, 16'h0000, 5};
        vecs[3] = '{1, 8'h80, 6, 16'h8001, 1, 8'h80, 16'h8001, 1};
        vecs[4] = '{2, 8'h33, 2, 16'h1234, 3, 8'h33, 16'h1234, 3};

        apply_reset();
        check_all_zero("reset");

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        check("vec retain data3", consumer_read_data[3], 16'h0000);
        check("vec retain data0", consumer_read_data[0], 16'hFFFF);

        // All four at once: strict order 0..3 from a fresh pointer.
        apply_reset();
        for (int i = 0; i < NC; i++) consumer_read_address[i] = 8'(16 + i);
        consumer_read_valid = '1;
        for (int k = 0; k < NC; k++) begin
            wait_mem_valid("all4");
            check($sformatf("all4 order%0d", k), mem_read_address, 8'(16 + k));
            serve(k, 1, 16'(16'hC000 + k), $sformatf("all4 c%0d", k));
        end
        check("all4 count", served_count, 4);
        check("all4 idle", busy, 0);
        for (int k = 0; k < NC; k++) check("all4 retain", consumer_read_data[k], 16'(16'hC000 + k));

        // Fairness: consumer 0 re-requests at once; consumer 3 must win next.
        apply_reset();
        consumer_read_address[0] = 8'h20;
        consumer_read_address[3] = 8'h23;
        consumer_read_valid      = 4'b1001;
        wait_mem_valid("fair1");
        check("fair first", mem_read_address, 8'h20);
        serve(0, 2, 16'h2020, "fair1");
        consumer_read_valid[0] = 1'b1;
        wait_mem_valid("fair2");
        check("fair second", mem_read_address, 8'h23);
        serve(3, 0, 16'h2323, "fair2");
        wait_mem_valid("fair3");
        check("fair third", mem_read_address, 8'h20);
        serve(0, 0, 16'h2021, "fair3");
        check("fair count", served_count, 3);

        // Reset during READ_WAIT, then a late memory completion.
        apply_reset();
        run_vec('{0, 8'h44, 0, 16'h4444, 1, 8'h44, 16'h4444, 1}, "pre");
        consumer_read_address[1] = 8'h55;
        consumer_read_valid[1]   = 1'b1;
        @(negedge clk);
        check("mid grant", mem_read_valid, 1);
        #1 reset = 1'b0;
        #1 check_all_zero("async reset");
        consumer_read_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        exp_count = 0;
        @(negedge clk);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        @(negedge clk);
        mem_read_ready = 1'b0;
        @(negedge clk);
        check_all_zero("late ready");
        consumer_read_address[0] = 8'h60;
        consumer_read_address[3] = 8'h63;
        consumer_read_valid      = 4'b1001;
        @(negedge clk);
        check("post reset ptr0", mem_read_address, 8'h60);
        serve(0, 0, 16'h6060, "post0");
        wait_mem_valid("post3");
        serve(3, 0, 16'h6363, "post3");

        // Spurious completion while idle.
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        @(negedge clk);
        mem_read_ready = 1'b0;
        @(negedge clk);
        check("spur mem_valid", mem_read_valid, 0);
        check("spur busy", busy, 0);
        check("spur ready", consumer_read_ready, 0);
        check("spur count", served_count, exp_count);
        check("spur data0", consumer_read_data[0], 16'h6060);
        check("spur data3", consumer_read_data[3], 16'h6363);

        // Randomized traffic against the transaction-level model.
        apply_reset();
        begin : random_phase
            int          cur;
            int          ptr_m;
            int          delay_left;
            int          hold_left;
            bit          mem_pend;
            bit          pulsed;
            bit          delivered;
            bit          dropped;
            bit          grant_due;
            logic [NC-1:0] v_snap;
            logic [15:0] exp_d;
            cur = -1; ptr_m = 0; delay_left = 0; hold_left = 0;
            mem_pend = 0; pulsed = 0; delivered = 0; dropped = 0; grant_due = 0;
            v_snap = '0; exp_d = '0;
            for (int it = 0; it < 800; it++) begin
                if (grant_due) begin
                    int g;
                    g = rr_pick(v_snap, ptr_m);
                    check("rand grant", mem_read_valid, 1);
                    check("rand addr", mem_read_address, consumer_read_address[g]);
                    cur        = g;
                    ptr_m      = (g + 1) % NC;
                    mem_pend   = 1;
                    delay_left = $urandom_range(0, 4);
                    grant_due  = 0;
                end
                if (pulsed) begin
                    check("rand ready", consumer_read_ready, 32'(1 << cur));
                    check("rand data", consumer_read_data[cur], exp_d);
                    pulsed    = 0;
                    delivered = 1;
                    hold_left = $urandom_range(0, 3);
                end
                if (dropped) begin
                    check("rand release", consumer_read_ready, 0);
                    check("rand count", served_count, exp_count);
                    check("rand idle", busy, 0);
                    dropped = 0;
                    cur     = -1;
                end

                mem_read_ready = 1'b0;
                if (cur >= 0 && mem_pend) begin
                    if (delay_left == 0) begin
                        exp_d          = mem_fn(consumer_read_address[cur]);
                        mem_read_ready = 1'b1;
                        mem_read_data  = exp_d;
                        mem_pend       = 0;
                        pulsed         = 1;
                    end else begin
                        delay_left--;
                    end
                end else if (cur >= 0 && delivered) begin
                    if (hold_left == 0) begin
                        consumer_read_valid[cur] = 1'b0;
                        delivered = 0;
                        dropped   = 1;
                        exp_count++;
                    end else begin
                        hold_left--;
                    end
                end
                for (int j = 0; j < NC; j++) begin
                    if (j != cur && !consumer_read_valid[j] && $urandom_range(0, 3) == 0) begin
                        consumer_read_address[j] = 8'($urandom);
                        consumer_read_valid[j]   = 1'b1;
                    end
                end
                if (cur < 0 && consumer_read_valid != '0) begin
                    grant_due = 1;
                    v_snap    = consumer_read_valid;
                end
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
